// File: rtl/model_state_vector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : model_state_vector_pkg
// Description : Shared sizes, FSM state encoding and width helpers for the
//               state-vector update block.
// Revision    : 1.0 - initial release
// ============================================================================
package model_state_vector_pkg;

   localparam int DATA_SIZE     = 64;
   localparam int CONTROL_SIZE  = 64;
   localparam int FRACTION_SIZE = 32;
   localparam int MAX_N         = 64;
   localparam int MAX_P         = 64;

   function automatic int acc_width(input int data_size);
      return 2 * data_size + 8;
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int ACC_SIZE = acc_width(DATA_SIZE);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_X = 3'd1,
      LOAD_U = 3'd2,
      ROW_A  = 3'd3,
      ROW_B  = 3'd4,
      EMIT   = 3'd5,
      DONE   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/model_state_vector_mac.sv
`default_nettype none
// ============================================================================
// Module      : model_state_vector_mac
// Description : Signed multiply-accumulate with fixed-point output stage.
//               Build option MODEL_STATE_VECTOR_SATURATE_EN clamps the output
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module model_state_vector_mac #(
   parameter int DATA_SIZE     = 64,
   parameter int FRACTION_SIZE = 32,
   parameter int ACC_SIZE      = 2 * DATA_SIZE + 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_clr,
   input  logic                        i_en,
   input  logic signed [DATA_SIZE-1:0] i_a,
   input  logic signed [DATA_SIZE-1:0] i_b,
   output logic        [DATA_SIZE-1:0] o_data
);

   logic signed [2*DATA_SIZE-1:0] w_prod;
   logic signed [ACC_SIZE-1:0]    w_base;
   logic signed [ACC_SIZE-1:0]    r_acc;

   assign w_prod = (2*DATA_SIZE)'(i_a) * (2*DATA_SIZE)'(i_b);
   // A clear coinciding with an accumulate starts the row at this product.
   assign w_base = i_clr ? '0 : r_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_base + ACC_SIZE'(w_prod);
      end else if (i_clr) begin
         r_acc <= '0;
      end
   end

`ifdef MODEL_STATE_VECTOR_SATURATE_EN
   logic signed [ACC_SIZE-1:0] w_shift;
   logic                       w_ovf;

   assign w_shift = r_acc >>> FRACTION_SIZE;
   assign w_ovf   = w_shift[ACC_SIZE-1:DATA_SIZE-1] !=
                    {(ACC_SIZE-DATA_SIZE+1){w_shift[ACC_SIZE-1]}};

   always_comb begin
      o_data = w_shift[DATA_SIZE-1:0];
      if (w_ovf) begin
         o_data = w_shift[ACC_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                      : {1'b0, {(DATA_SIZE-1){1'b1}}};
      end
   end
`else
   assign o_data = DATA_SIZE'(r_acc >>> FRACTION_SIZE);
`endif

endmodule
`default_nettype wire

// File: rtl/model_state_vector_state.sv
`default_nettype none
// ============================================================================
// Module      : model_state_vector_state
// Description : Computes x(k+1) = A*x(k) + B*u(k) from streamed vectors and
//               row-major matrices. Optional MODEL_STATE_VECTOR_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module model_state_vector_state #(
   parameter int DATA_SIZE     = model_state_vector_pkg::DATA_SIZE,
   parameter int CONTROL_SIZE  = model_state_vector_pkg::CONTROL_SIZE,
   parameter int FRACTION_SIZE = model_state_vector_pkg::FRACTION_SIZE,
   parameter int MAX_N         = model_state_vector_pkg::MAX_N,
   parameter int MAX_P         = model_state_vector_pkg::MAX_P
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   output logic                    ERROR_OUT,
   input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
   input  logic [CONTROL_SIZE-1:0] SIZE_P_IN,
   input  logic                    DATA_IN_VALID,
   output logic                    DATA_IN_READY,
   input  logic [DATA_SIZE-1:0]    DATA_IN,
   output logic                    DATA_OUT_VALID,
   input  logic                    DATA_OUT_READY,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic                    DATA_OUT_LAST
);
   import model_state_vector_pkg::*;

   localparam int c_ACC_SIZE = acc_width(DATA_SIZE);
   localparam int c_N_W      = idx_width(MAX_N);
   localparam int c_P_W      = idx_width(MAX_P);
   localparam int c_J_W      = (c_N_W > c_P_W) ? c_N_W : c_P_W;

   state_t               r_state;
   logic [c_J_W-1:0]     r_j;
   logic [c_J_W-1:0]     r_i;
   logic [c_J_W-1:0]     r_n_last;
   logic [c_J_W-1:0]     r_p_last;
   logic                 r_err;
   logic [DATA_SIZE-1:0] r_xbuf [MAX_N];
   logic [DATA_SIZE-1:0] r_ubuf [MAX_P];

   logic                 w_in_fire;
   logic                 w_out_fire;
   logic                 w_size_bad;
   logic                 w_j_last_n;
   logic                 w_j_last_p;
   logic                 w_mac_en;
   logic                 w_mac_clr;
   logic [DATA_SIZE-1:0] w_mul_b;
   logic [DATA_SIZE-1:0] w_mac_out;

   assign DATA_IN_READY  = (r_state == LOAD_X) || (r_state == LOAD_U) ||
                           (r_state == ROW_A)  || (r_state == ROW_B);
   assign DATA_OUT_VALID = (r_state == EMIT);
   assign DATA_OUT_LAST  = (r_state == EMIT) && (r_i == r_n_last);
   assign DATA_OUT       = (r_state == EMIT) ? w_mac_out : '0;
   assign READY          = (r_state == DONE);
   assign ERROR_OUT      = (r_state == DONE) && r_err;

   assign w_in_fire  = DATA_IN_VALID && DATA_IN_READY;
   assign w_out_fire = DATA_OUT_VALID && DATA_OUT_READY;
   assign w_j_last_n = (r_j == r_n_last);
   assign w_j_last_p = (r_j == r_p_last);

   assign w_size_bad = (SIZE_N_IN == '0) || (SIZE_P_IN == '0) ||
                       (SIZE_N_IN > CONTROL_SIZE'(MAX_N)) ||
                       (SIZE_P_IN > CONTROL_SIZE'(MAX_P));

   assign w_mac_en  = w_in_fire && ((r_state == ROW_A) || (r_state == ROW_B));
   assign w_mac_clr = (r_state == ROW_A) && (r_j == '0);
   assign w_mul_b   = (r_state == ROW_B) ? r_ubuf[r_j[c_P_W-1:0]]
                                         : r_xbuf[r_j[c_N_W-1:0]];

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_j      <= '0;
         r_i      <= '0;
         r_n_last <= '0;
         r_p_last <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_n_last <= c_J_W'(SIZE_N_IN - CONTROL_SIZE'(1));
                  r_p_last <= c_J_W'(SIZE_P_IN - CONTROL_SIZE'(1));
                  r_j      <= '0;
                  r_i      <= '0;
                  r_err    <= w_size_bad;
                  r_state  <= w_size_bad ? DONE : LOAD_X;
               end
            end
            LOAD_X: begin
               if (w_in_fire) begin
                  r_j     <= w_j_last_n ? '0 : r_j + c_J_W'(1);
                  r_state <= w_j_last_n ? LOAD_U : LOAD_X;
               end
            end
            LOAD_U: begin
               if (w_in_fire) begin
                  r_j     <= w_j_last_p ? '0 : r_j + c_J_W'(1);
                  r_state <= w_j_last_p ? ROW_A : LOAD_U;
               end
            end
            ROW_A: begin
               if (w_in_fire) begin
                  r_j     <= w_j_last_n ? '0 : r_j + c_J_W'(1);
                  r_state <= w_j_last_n ? ROW_B : ROW_A;
               end
            end
            ROW_B: begin
               if (w_in_fire) begin
                  r_j     <= w_j_last_p ? '0 : r_j + c_J_W'(1);
                  r_state <= w_j_last_p ? EMIT : ROW_B;
               end
            end
            EMIT: begin
               if (w_out_fire) begin
                  if (r_i == r_n_last) begin
                     r_state <= DONE;
                  end else begin
                     r_i     <= r_i + c_J_W'(1);
                     r_state <= ROW_A;
                  end
               end
            end
            DONE: begin
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Vector buffers carry no reset; their contents are only read after a load.
   always_ff @(posedge CLK) begin
      if (w_in_fire && (r_state == LOAD_X)) begin
         r_xbuf[r_j[c_N_W-1:0]] <= DATA_IN;
      end
      if (w_in_fire && (r_state == LOAD_U)) begin
         r_ubuf[r_j[c_P_W-1:0]] <= DATA_IN;
      end
   end

   model_state_vector_mac #(
      .DATA_SIZE     (DATA_SIZE),
      .FRACTION_SIZE (FRACTION_SIZE),
      .ACC_SIZE      (c_ACC_SIZE)
   ) u_mac (
      .clk    (CLK),
      .rst    (RST),
      .i_clr  (w_mac_clr),
      .i_en   (w_mac_en),
      .i_a    (DATA_IN),
      .i_b    (w_mul_b),
      .o_data (w_mac_out)
   );

endmodule
`default_nettype wire

// File: tb/tb_model_state_vector_state.sv
`default_nettype none
// ============================================================================
// Module      : tb_model_state_vector_state
// Description : Directed checks on an integer-format (FRACTION_SIZE=0) and a
//               Q32.32 instance. Honours MODEL_STATE_VECTOR_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_model_state_vector_state;

   localparam int c_BUDGET = 60;
`ifdef MODEL_STATE_VECTOR_SATURATE_EN
   localparam logic [63:0] c_OVF_EXP = 64'h7FFF_FFFF_FFFF_FFFF;
`else
   localparam logic [63:0] c_OVF_EXP = 64'h0;
`endif

   // Packed lists: element 0 is rightmost; matrices indexed [i*2+j].
   typedef struct {
      int               d;
      int               n;
      int               p;
      logic [1:0][63:0] x;
      logic [1:0][63:0] u;
      logic [3:0][63:0] a;
      logic [3:0][63:0] b;
      logic [1:0][63:0] ex;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start      [2];
   logic [63:0] size_n     [2];
   logic [63:0] size_p     [2];
   logic        din_valid  [2];
   logic [63:0] din        [2];
   logic        dout_ready [2];
   logic        ready      [2];
   logic        err        [2];
   logic        din_ready  [2];
   logic        dout_valid [2];
   logic [63:0] dout       [2];
   logic        dout_last  [2];

   int   checks = 0;
   int   errors = 0;
   vec_t vt [6];

   always #5 clk = ~clk;

   model_state_vector_state #(.FRACTION_SIZE(0)) u_dut_q0 (
      .CLK(clk), .RST(rst), .START(start[0]), .READY(ready[0]), .ERROR_OUT(err[0]),
      .SIZE_N_IN(size_n[0]), .SIZE_P_IN(size_p[0]),
      .DATA_IN_VALID(din_valid[0]), .DATA_IN_READY(din_ready[0]), .DATA_IN(din[0]),
      .DATA_OUT_VALID(dout_valid[0]), .DATA_OUT_READY(dout_ready[0]),
      .DATA_OUT(dout[0]), .DATA_OUT_LAST(dout_last[0])
   );

   model_state_vector_state u_dut_q32 (
      .CLK(clk), .RST(rst), .START(start[1]), .READY(ready[1]), .ERROR_OUT(err[1]),
      .SIZE_N_IN(size_n[1]), .SIZE_P_IN(size_p[1]),
      .DATA_IN_VALID(din_valid[1]), .DATA_IN_READY(din_ready[1]), .DATA_IN(din[1]),
      .DATA_OUT_VALID(dout_valid[1]), .DATA_OUT_READY(dout_ready[1]),
      .DATA_OUT(dout[1]), .DATA_OUT_LAST(dout_last[1])
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int d, input int n, input int p,
                               input logic [1:0][63:0] x, input logic [1:0][63:0] u,
                               input logic [3:0][63:0] a, input logic [3:0][63:0] b,
                               input logic [1:0][63:0] ex);
      vec_t v;
      v.d = d; v.n = n; v.p = p; v.x = x; v.u = u; v.a = a; v.b = b; v.ex = ex;
      return v;
   endfunction

   task automatic begin_op(input int d, input int n, input int p);
      start[d]  = 1'b1;
      size_n[d] = 64'(n);
      size_p[d] = 64'(p);
      @(posedge clk); #1;
      start[d]  = 1'b0;
   endtask

   task automatic drive(input int d, input logic [63:0] q[$]);
      int cnt;
      for (int k = 0; k < q.size(); k++) begin
         din_valid[d] = 1'b1;
         din[d]       = q[k];
         cnt          = 0;
         while (!din_ready[d] && cnt < c_BUDGET) begin
            @(posedge clk); #1;
            cnt++;
         end
         if (!din_ready[d]) begin
            chk("in_timeout", 64'(din_ready[d]), 64'd1);
            break;
         end
         @(posedge clk); #1;
      end
      din_valid[d] = 1'b0;
   endtask

   task automatic collect(input int d, input int n, input logic [1:0][63:0] ex,
                          input int hold);
      int cnt;
      dout_ready[d] = (hold == 0);
      for (int r = 0; r < n; r++) begin
         cnt = 0;
         while (!dout_valid[d] && cnt < c_BUDGET) begin
            @(posedge clk); #1;
            cnt++;
         end
         if (!dout_valid[d]) begin
            chk("out_timeout", 64'(dout_valid[d]), 64'd1);
            dout_ready[d] = 1'b1;
            return;
         end
         if (r == 0 && hold > 0) begin
            for (int h = 0; h < hold; h++) begin
               chk("bp_valid", 64'(dout_valid[d]), 64'd1);
               chk("bp_data", dout[d], ex[0]);
               chk("bp_in_ready", 64'(din_ready[d]), 64'd0);
               @(posedge clk); #1;
            end
            dout_ready[d] = 1'b1;
         end
         chk("dout", dout[d], ex[r]);
         chk("last", 64'(dout_last[d]), 64'(r == n - 1));
         @(posedge clk); #1;
      end
      chk("ready_pulse", 64'(ready[d]), 64'd1);
      chk("no_error", 64'(err[d]), 64'd0);
      @(posedge clk); #1;
      chk("ready_low", 64'(ready[d]), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input int hold);
      logic [63:0] q[$];
      q = {};
      for (int j = 0; j < v.n; j++) q.push_back(v.x[j]);
      for (int j = 0; j < v.p; j++) q.push_back(v.u[j]);
      for (int i = 0; i < v.n; i++) begin
         for (int j = 0; j < v.n; j++) q.push_back(v.a[i*2+j]);
         for (int j = 0; j < v.p; j++) q.push_back(v.b[i*2+j]);
      end
      begin_op(v.d, v.n, v.p);
      fork
         drive(v.d, q);
         collect(v.d, v.n, v.ex, hold);
      join
   endtask

   task automatic check_illegal(input int d, input int n, input int p);
      begin_op(d, n, p);
      chk("bad_ready", 64'(ready[d]), 64'd1);
      chk("bad_error", 64'(err[d]), 64'd1);
      chk("bad_in_ready", 64'(din_ready[d]), 64'd0);
      @(posedge clk); #1;
      chk("bad_ready_low", 64'(ready[d]), 64'd0);
      chk("bad_error_low", 64'(err[d]), 64'd0);
      chk("bad_in_ready_low", 64'(din_ready[d]), 64'd0);
   endtask

   task automatic check_idle_outputs(input int d);
      chk("idle_ready", 64'(ready[d]), 64'd0);
      chk("idle_error", 64'(err[d]), 64'd0);
      chk("idle_in_ready", 64'(din_ready[d]), 64'd0);
      chk("idle_out_valid", 64'(dout_valid[d]), 64'd0);
      chk("idle_out_last", 64'(dout_last[d]), 64'd0);
      chk("idle_dout", dout[d], 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [63:0] q[$];
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; size_n[d] = '0; size_p[d] = '0;
         din_valid[d] = 1'b0; din[d] = '0; dout_ready[d] = 1'b1;
      end

      vt[0] = mk(0, 2, 1, {64'd4, 64'd3}, {64'd0, 64'd5},
                 {64'd1, 64'd0, 64'd0, 64'd1}, {64'd0, 64'd2, 64'd0, 64'd1},
                 {64'd14, 64'd8});
      vt[1] = mk(1, 1, 1, {64'd0, 64'h1_0000_0000}, {64'd0, 64'h8000_0000},
                 {64'd0, 64'd0, 64'd0, 64'h2_0000_0000},
                 {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_0000_0000},
                 {64'd0, 64'h1_8000_0000});
      vt[2] = mk(0, 1, 1, {64'd0, 64'h4000_0000_0000_0000}, {64'd0, 64'd0},
                 {64'd0, 64'd0, 64'd0, 64'h4000_0000_0000_0000},
                 {64'd0, 64'd0, 64'd0, 64'd0}, {64'd0, c_OVF_EXP});
      vt[3] = mk(0, 2, 2, {64'd7, -64'sd2}, {-64'sd1, 64'd3},
                 {-64'sd4, 64'd3, 64'd2, 64'd1}, {64'd8, -64'sd7, 64'd6, 64'd5},
                 {-64'sd63, 64'd21});
      vt[4] = mk(1, 2, 1, {64'hFFFF_FFFF_0000_0000, 64'h4000_0000},
                 {64'd0, 64'h2_0000_0000},
                 {64'h8000_0000, 64'h8000_0000, 64'h1_0000_0000, 64'h4_0000_0000},
                 {64'd0, 64'hFFFF_FFFF_C000_0000, 64'd0, 64'h8000_0000},
                 {64'hFFFF_FFFF_2000_0000, 64'h1_0000_0000});
      vt[5] = mk(1, 1, 1, {64'd0, 64'd1}, {64'd0, 64'd0},
                 {64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
                 {64'd0, 64'd0, 64'd0, 64'd0}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_idle_outputs(0);
      check_idle_outputs(1);

      // Stray input traffic while idle must not be consumed.
      din_valid[0] = 1'b1;
      din[0]       = 64'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_ignores_in", 64'(din_ready[0]), 64'd0);
      din_valid[0] = 1'b0;

      for (int k = 0; k < 6; k++) run_vec(vt[k], 0);

      run_vec(vt[0], 5);
      run_vec(vt[4], 5);

      check_illegal(0, 0, 1);
      check_illegal(0, 1, 0);
      check_illegal(1, 1, 65);
      check_illegal(1, 65, 1);

      // Abort from ROW_B: x, u and row 0 of A accepted, then reset.
      begin_op(0, 2, 1);
      q = {64'd3, 64'd4, 64'd5, 64'd1, 64'd0};
      drive(0, q);
      chk("rowb_in_ready", 64'(din_ready[0]), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle_outputs(0);
      chk("abort_no_ready", 64'(ready[0]), 64'd0);
      run_vec(vt[0], 0);
      run_vec(vt[3], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
